// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the start-bit qualifier / line side and the RX frame sequencer.
// UART_RX_PARITY_EN adds o_parity_err alongside o_valid.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_en;
    logic                 i_rx;
    logic                 i_found;
    logic                 o_hunt;
    logic                 o_busy;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 o_parity_err;
`endif
    logic [1:0]           o_dbg_state;

    // o_valid/o_frame_err are one-cycle strobes with no back-pressure: the consumer
    // must capture o_data in the cycle o_valid is high; o_data then holds until the next good frame.
    modport master (
        output i_en, i_rx, i_found,
        input  o_hunt, o_busy, o_data, o_valid, o_frame_err,
`ifdef UART_RX_PARITY_EN
        input  o_parity_err,
`endif
        input  o_dbg_state
    );

    modport slave (
        input  i_en, i_rx, i_found,
        output o_hunt, o_busy, o_data, o_valid, o_frame_err,
`ifdef UART_RX_PARITY_EN
        output o_parity_err,
`endif
        output o_dbg_state
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: samples data/stop bits at bit centres on oversample ticks.
// Optional parity bit and o_parity_err when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input logic           i_clk,
    input logic           i_rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int TW = $clog2(OSR);
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_STOP   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif

    // Tick counter restarts at the start-bit centre, so OSR-1 lands on each following bit centre.
    logic sample;
    assign sample = bus.i_en && (tick_q == TW'(OSR - 1));

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        if (bus.i_en && state_q != ST_IDLE) begin
            tick_d = sample ? '0 : tick_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (bus.i_en && bus.i_found) begin
                    state_d = ST_DATA;
                    tick_d  = '0;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shift_d = {bus.i_rx, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample) begin
                    par_bad_d = bus.i_rx ^ (^shift_q) ^ PARITY_ODD;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (sample) begin
                    if (bus.i_rx) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_bad_q;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.o_hunt      = (state_q == ST_IDLE);
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err = perr_q;
`endif
    assign bus.o_dbg_state = state_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frames built from a bit-list model, randomized line noise.
// Parity scenarios are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_ctrl;
    localparam int OSR       = 16;
    localparam int DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.DATA_BITS(DATA_BITS)) bus_if ();

    uart_rx_ctrl #(.OSR(OSR), .DATA_BITS(DATA_BITS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if)
    );

    int tests = 0;
    int fails = 0;
    int n_valid = 0, n_ferr = 0, n_perr = 0, n_both = 0;
    logic [DATA_BITS-1:0] exp_q[$];
    logic [DATA_BITS-1:0] obs_q[$];
    logic [DATA_BITS-1:0] last_good = '0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse monitor samples shortly after the active edge.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            if (bus_if.o_valid) begin
                n_valid++;
                obs_q.push_back(bus_if.o_data);
            end
            if (bus_if.o_frame_err) n_ferr++;
            if (bus_if.o_valid && bus_if.o_frame_err) n_both++;
`ifdef UART_RX_PARITY_EN
            if (bus_if.o_parity_err) n_perr++;
`endif
        end
    end

    task automatic drive(input logic en, input logic rx, input logic found);
        bus_if.i_en    = en;
        bus_if.i_rx    = rx;
        bus_if.i_found = found;
    endtask

    task automatic idle(input int n, input int en_per);
        repeat (n) begin
            drive(1'($urandom_range(0, en_per - 1) == 0), 1'b1, 1'b0);
            @(negedge clk);
        end
    endtask

    // Called at a negedge with the cycle's inputs not yet driven; returns in the same position.
    task automatic run_frame(input logic [DATA_BITS-1:0] data, input bit stop, input int en_per,
                             input bit par_ok, input int abort_at);
        bit line[$];
        int nb;
        int bad;
        logic exp_perr;
        for (int i = 0; i < DATA_BITS; i++) line.push_back(data[i]);
        if (PAR_EN) line.push_back(par_ok ? ^data : ~^data);
        line.push_back(stop);
        nb = line.size();
        bad = 0;

        tests++;
        if (bus_if.o_hunt !== 1'b1) begin
            fails++;
            $display("FAIL hunt_before_found: got %b want 1", bus_if.o_hunt);
        end
        drive(1'b1, 1'b0, 1'b1);

        for (int t = 1; t <= nb * OSR; t++) begin
            for (int k = 1; k < en_per; k++) begin
                @(negedge clk);
                if (bus_if.o_busy !== 1'b1 || bus_if.o_valid !== 1'b0 || bus_if.o_frame_err !== 1'b0) bad++;
                drive(1'b0, 1'($urandom), 1'($urandom));
            end
            @(negedge clk);
            if (bus_if.o_busy !== 1'b1 || bus_if.o_valid !== 1'b0 || bus_if.o_frame_err !== 1'b0) bad++;
            if (t == abort_at) begin
                tests++;
                if (bad !== 0) begin
                    fails++;
                    $display("FAIL in_frame_before_abort: bad cycles %0d want 0", bad);
                end
                return;
            end
            drive(1'b1, (t % OSR == 0) ? line[t / OSR - 1] : 1'($urandom),
                  (t == nb * OSR) ? 1'b0 : 1'($urandom));
        end
        @(negedge clk);

        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL in_frame: bad cycles %0d want 0 (data %h)", bad, data);
        end
        tests++;
        if (bus_if.o_valid !== stop) begin
            fails++;
            $display("FAIL valid_latency: got %b want %b (data %h)", bus_if.o_valid, stop, data);
        end
        tests++;
        if (bus_if.o_frame_err !== !stop) begin
            fails++;
            $display("FAIL frame_err: got %b want %b (data %h)", bus_if.o_frame_err, !stop, data);
        end
        if (stop) begin
            last_good = data;
            exp_q.push_back(data);
        end
        tests++;
        if (bus_if.o_data !== last_good) begin
            fails++;
            $display("FAIL data_out: got %h want %h", bus_if.o_data, last_good);
        end
        tests++;
        if (bus_if.o_hunt !== 1'b1 || bus_if.o_busy !== 1'b0) begin
            fails++;
            $display("FAIL rearm: hunt %b busy %b want 1 0", bus_if.o_hunt, bus_if.o_busy);
        end
        exp_perr = PAR_EN && stop && !par_ok;
`ifdef UART_RX_PARITY_EN
        tests++;
        if (bus_if.o_parity_err !== exp_perr) begin
            fails++;
            $display("FAIL parity_err: got %b want %b (data %h)", bus_if.o_parity_err, exp_perr, data);
        end
`else
        if (exp_perr) $display("note: parity expectation without parity build");
`endif
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        repeat (n) @(negedge clk);
        rst = 1'b0;
        last_good = '0;
    endtask

    task automatic check_counts(input string name, input int v0, input int f0, input int dv, input int df);
        tests++;
        if (n_valid - v0 !== dv || n_ferr - f0 !== df) begin
            fails++;
            $display("FAIL %s: valid/frame_err pulses %0d/%0d want %0d/%0d", name, n_valid - v0, n_ferr - f0, dv, df);
        end
    endtask

    task automatic test_reset();
        int v0, f0, bad;
        do_reset(3);
        tests++;
        if (bus_if.o_hunt !== 1'b1 || bus_if.o_busy !== 1'b0 || bus_if.o_data !== '0 ||
            bus_if.o_valid !== 1'b0 || bus_if.o_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: hunt %b busy %b data %h valid %b ferr %b want 1 0 00 0 0",
                     bus_if.o_hunt, bus_if.o_busy, bus_if.o_data, bus_if.o_valid, bus_if.o_frame_err);
        end
        v0 = n_valid; f0 = n_ferr; bad = 0;
        repeat (1000) begin
            drive(1'b1, 1'b1, 1'b0);
            @(negedge clk);
            if (bus_if.o_hunt !== 1'b1 || bus_if.o_busy !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL idle_1000: bad cycles %0d want 0", bad);
        end
        check_counts("idle_pulses", v0, f0, 0, 0);
    endtask

    task automatic test_found_gating();
        int bad = 0;
        repeat (6) begin
            drive(1'b0, 1'($urandom), 1'b1);
            @(negedge clk);
            if (bus_if.o_hunt !== 1'b1 || bus_if.o_busy !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL found_without_en: busy cycles %0d want 0", bad);
        end
    endtask

    task automatic test_basic();
        int v0 = n_valid, f0 = n_ferr;
        run_frame(8'hA5, 1'b1, 1, 1'b1, -1);
        idle(4, 1);
        check_counts("basic_a5", v0, f0, 1, 0);
    endtask

    task automatic test_frame_err();
        int v0 = n_valid, f0 = n_ferr;
        run_frame(8'h3C, 1'b0, 1, 1'b1, -1);
        idle(4, 1);
        check_counts("frame_err_3c", v0, f0, 0, 1);
        tests++;
        if (bus_if.o_data !== 8'hA5) begin
            fails++;
            $display("FAIL data_hold: got %h want a5", bus_if.o_data);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = n_valid, f0 = n_ferr;
        run_frame(8'h00, 1'b1, 3, 1'b1, -1);
        run_frame(8'hFF, 1'b1, 3, 1'b1, -1);
        run_frame(8'h5A, 1'b1, 1, 1'b1, -1);
        run_frame(8'hC3, 1'b1, 1, 1'b1, -1);
        idle(6, 3);
        check_counts("back_to_back", v0, f0, 4, 0);
    endtask

    task automatic test_reset_mid_frame();
        int v0, f0;
        run_frame(8'h55, 1'b1, 1, 1'b1, 4 * OSR + OSR / 2);
        do_reset(2);
        v0 = n_valid; f0 = n_ferr;
        tests++;
        if (bus_if.o_hunt !== 1'b1 || bus_if.o_busy !== 1'b0 || bus_if.o_data !== '0) begin
            fails++;
            $display("FAIL reset_abort: hunt %b busy %b data %h want 1 0 00",
                     bus_if.o_hunt, bus_if.o_busy, bus_if.o_data);
        end
        idle(5, 1);
        run_frame(8'h81, 1'b1, 1, 1'b1, -1);
        idle(4, 1);
        check_counts("after_reset_81", v0, f0, 1, 0);
    endtask

    task automatic test_random();
        int v0 = n_valid, f0 = n_ferr, ev = 0, ef = 0;
        for (int i = 0; i < 12; i++) begin
            logic [DATA_BITS-1:0] d;
            bit stop;
            d = DATA_BITS'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            if (stop) ev++; else ef++;
            run_frame(d, stop, $urandom_range(1, 3), PAR_EN ? 1'($urandom) : 1'b1, -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20), 2);
        end
        idle(4, 1);
        check_counts("random_frames", v0, f0, ev, ef);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int p0 = n_perr;
        run_frame(8'h07, 1'b1, 1, 1'b0, -1);
        run_frame(8'h07, 1'b1, 1, 1'b1, -1);
        run_frame(8'h07, 1'b0, 1, 1'b0, -1);
        idle(4, 1);
        tests++;
        if (n_perr - p0 !== 1) begin
            fails++;
            $display("FAIL parity_pulses: got %0d want 1", n_perr - p0);
        end
    endtask
`endif

    task automatic test_scoreboard();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL byte_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [DATA_BITS-1:0] o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL byte_order: got %h want %h", o, e);
            end
        end
        tests++;
        if (n_both !== 0) begin
            fails++;
            $display("FAIL pulse_overlap: got %0d want 0", n_both);
        end
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        test_reset();
        test_found_gating();
        test_basic();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_scoreboard();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
